// File: rtl/sys_gpio_debounce.sv
// sys_gpio_debounce: per-bit synchroniser + stability filter ahead of a GPIO PIO.
// Ports: clk, reset_n (async low), raw_in -> filt_out, Avalon slave
// (address, chipselect, write_n, writedata, readdata). Optional mask: GPIO_DB_BYPASS_EN.
module sys_gpio_debounce #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 4,
  parameter int PRESCALE_RST = 999,
  parameter int THRESH_RST   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] filt_out,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata
);

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            filt_q, filt_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]                 pre_cnt_q, pre_cnt_d;
  logic [15:0]                 prescale_q, prescale_d;
  logic [CNT_W-1:0]            thresh_q, thresh_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic [WIDTH-1:0]            byp;
  logic                        wr;
  logic                        tick;
  logic [CNT_W:0]              thr_eff;
  logic [CNT_W:0]              cnt_inc;
  logic [31:0]                 filt_rd;
  logic [31:0]                 byp_rd;

  assign wr = chipselect && !write_n;

`ifdef GPIO_DB_BYPASS_EN
  logic [WIDTH-1:0] bypass_q, bypass_d;

  always_comb begin
    bypass_d = bypass_q;
    if (wr && address == 2'd3)
      bypass_d = writedata[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bypass_q <= '0;
    else          bypass_q <= bypass_d;
  end

  assign byp = bypass_q;
`else
  assign byp = '0;
`endif

  always_comb begin
    s1_d = raw_in;
    s2_d = s1_q;

    tick      = (pre_cnt_q == prescale_q);
    pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    if (wr && address == 2'd1)
      pre_cnt_d = 16'd0;

    prescale_d = prescale_q;
    if (wr && address == 2'd1)
      prescale_d = writedata[15:0];

    thresh_d = thresh_q;
    if (wr && address == 2'd2)
      thresh_d = writedata[CNT_W-1:0];

    // A zero threshold still needs one tick of agreement.
    thr_eff = (thresh_q == '0) ? {{CNT_W{1'b0}}, 1'b1}
                               : {1'b0, thresh_q};

    filt_d  = filt_q;
    cnt_d   = cnt_q;
    cnt_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Extra bit keeps the compare exact if threshold drops under cnt.
      cnt_inc = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
      if (byp[i]) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick && cnt_inc >= thr_eff) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (tick) begin
        cnt_d[i] = cnt_inc[CNT_W-1:0];
      end
    end

    filt_rd = '0;
    filt_rd[WIDTH-1:0] = filt_q;
    byp_rd = '0;
    byp_rd[WIDTH-1:0] = byp;

    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d = filt_rd;
      2'd1: readdata_d = {16'd0, prescale_q};
      2'd2: readdata_d = {{(32-CNT_W){1'b0}}, thresh_q};
      2'd3: readdata_d = byp_rd;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      cnt_q      <= '0;
      pre_cnt_q  <= '0;
      prescale_q <= 16'(PRESCALE_RST);
      thresh_q   <= CNT_W'(THRESH_RST);
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      prescale_q <= prescale_d;
      thresh_q   <= thresh_d;
      readdata_q <= readdata_d;
    end
  end

  assign filt_out = filt_q;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_sys_gpio_debounce.sv
// tb_sys_gpio_debounce: random stimulus, tick-arithmetic reference model,
// scoreboard queues popped by a negedge monitor.
module tb_sys_gpio_debounce;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] raw_in;
  logic [31:0] filt_out;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] fq[$];
  logic [31:0] rq[$];

  sys_gpio_debounce dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .filt_out  (filt_out),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata)
  );

  always #5 clk = ~clk;

  // Reference model: ticks derived from elapsed cycles since the last
  // prescaler restart; a bit commits once its current disagreement run
  // has spanned thr_eff ticks.
  longint      cyc     = 0;
  longint      origin  = 0;
  longint      n_ticks = 0;
  longint      base [32];
  bit   [31:0] pend;
  int          m_p;
  int          m_thr;
  logic [31:0] m_mask;
  logic [31:0] m_s1, m_s2, m_filt;

  always @(posedge clk) begin
    logic [31:0] nf;
    logic [31:0] rd;
    bit          tk;
    int          te;
    longint      k;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; pend = '0;
      m_p = 999; m_thr = 8; m_mask = '0;
      origin = cyc + 1;
      fq.push_back(32'd0);
      rq.push_back(32'd0);
    end else begin
      k  = cyc - origin;
      tk = ((k % (m_p + 1)) == m_p);
      te = (m_thr == 0) ? 1 : m_thr;
      case (address)
        2'd0: rd = m_filt;
        2'd1: rd = m_p;
        2'd2: rd = m_thr;
        default: rd = m_mask;
      endcase
      rq.push_back(rd);
      nf = m_filt;
      for (int i = 0; i < 32; i++) begin
        if (m_mask[i]) begin
          nf[i] = m_s2[i]; pend[i] = 0;
        end else if (m_s2[i] == m_filt[i]) begin
          pend[i] = 0;
        end else begin
          if (!pend[i]) begin pend[i] = 1; base[i] = n_ticks; end
          if (tk && (n_ticks + 1 - base[i]) >= te) begin
            nf[i] = m_s2[i]; pend[i] = 0;
          end
        end
      end
      if (tk) n_ticks++;
      if (chipselect && !write_n) begin
        case (address)
          2'd1: begin m_p = int'(writedata[15:0]); origin = cyc + 1; end
          2'd2: m_thr = int'(writedata[3:0]);
          2'd3: begin
`ifdef GPIO_DB_BYPASS_EN
            m_mask = writedata;
`endif
          end
          default: ;
        endcase
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
      m_filt = nf;
      fq.push_back(m_filt);
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (fq.size() > 0) begin
      e = fq.pop_front();
      n_chk++;
      if (filt_out !== e) begin
        n_fail++;
        $display("FAIL filt_out t=%0t got %h exp %h", $time, filt_out, e);
      end
    end
    if (rq.size() > 0) begin
      e = rq.pop_front();
      n_chk++;
      if (readdata !== e) begin
        n_fail++;
        $display("FAIL readdata t=%0t got %h exp %h", $time, readdata, e);
      end
    end
  end

  task automatic run(int n, int h);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'b1;
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom();
      if (h > 0)
        for (int i = 0; i < 32; i++)
          if ($urandom_range(0, h - 1) == 0) raw_in[i] = ~raw_in[i];
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    run(1, 0);
  endtask

  task automatic check_now(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    raw_in     = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset values via the read port, slow default prescaler.
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      address = 2'(a);
    end
    run(40, 8);

    // Fast tick, threshold 3: random bounce of varied duty.
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd3);
    raw_in = '0;
    run(10, 0);
    raw_in[5] = 1'b1;
    run(12, 0);
    run(300, 2);
    run(300, 5);

    // Zero threshold behaves as one.
    wr(2'd2, 32'd0);
    run(200, 3);

    // Slower tick with threshold 2.
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd2);
    raw_in = '0;
    run(20, 0);
    raw_in[31] = 1'b1;
    run(25, 0);
    run(600, 12);

    // Threshold lowered below a pending count.
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd15);
    raw_in = '0;
    run(30, 0);
    raw_in[1] = 1'b1;
    run(8, 0);
    wr(2'd2, 32'd2);
    run(6, 0);

    // Mask register write, then random mask activity.
    wr(2'd3, 32'hFFFF_FFFF);
    @(negedge clk); chipselect = 1'b0; address = 2'd3;
    @(negedge clk);
    run(100, 1);
    wr(2'd3, $urandom());
    run(100, 2);
    wr(2'd3, 32'd0);
    run(100, 3);

    // Reset while bit 2 is mid-count after committing high.
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd8);
    raw_in = '0;
    run(30, 0);
    raw_in[2] = 1'b1;
    run(15, 0);
    raw_in[2] = 1'b0;
    run(5, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_now("async_rst_filt", filt_out, 32'd0);
    check_now("async_rst_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chipselect = 1'b0;
    address = 2'd0;
    raw_in = '1;
    repeat (8100) @(negedge clk);
    check_now("post_rst_high", filt_out, 32'hFFFF_FFFF);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
